// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared TMDS definitions for the receive path:
//   - CTRLTOKEN0..3 : the four 10-bit control tokens ({c1,c0} = 00,01,10,11)
//   - align_state_e : word-aligner state (SEARCH, LOCKED)
//   - is_ctrl_token : token detector
//   - tmds_decode   : 10-bit data symbol -> 8-bit pixel component
// -----------------------------------------------------------------------------
package tmds_pkg;

  localparam logic [9:0] CTRLTOKEN0 = 10'b1101010100;
  localparam logic [9:0] CTRLTOKEN1 = 10'b0010101011;
  localparam logic [9:0] CTRLTOKEN2 = 10'b0101010100;
  localparam logic [9:0] CTRLTOKEN3 = 10'b1010101011;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_e;

  function automatic logic is_ctrl_token(input logic [9:0] sym);
    return (sym == CTRLTOKEN0) || (sym == CTRLTOKEN1) ||
           (sym == CTRLTOKEN2) || (sym == CTRLTOKEN3);
  endfunction

  // Undo the optional inversion (bit 9), then undo the XOR/XNOR chain (bit 8).
  function automatic logic [7:0] tmds_decode(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] q;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    q    = 8'h00;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_word_align.sv
// -----------------------------------------------------------------------------
// tmds_word_align
// Two-word history of the deserialized stream and a 10-of-19 bit select that
// extracts the symbol starting at bit position offset_i.
// Ports:
//   clk_i    : pixel clock
//   rst_i    : asynchronous active-high reset
//   din_i    : raw 10-bit word, bit 0 earliest serial bit
//   offset_i : bit-slip offset, 0..9
//   sym_o    : registered candidate symbol
// -----------------------------------------------------------------------------
module tmds_word_align (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] din_i,
  input  logic [3:0] offset_i,
  output logic [9:0] sym_o
);

  logic [9:0]  raw_q;
  logic [9:0]  raw_p_q;
  logic [9:0]  sym_q;
  logic [18:0] window_s;
  logic [9:0]  cand_s;

  // raw_q holds the newer word; the newest word's top bit is never part of a
  // symbol until it has moved into raw_p_q, so the window is only 19 bits.
  assign window_s = {raw_q[8:0], raw_p_q};

  // Barrel select of the candidate symbol at the current bit offset.
  always_comb begin
    cand_s = window_s[9:0];
    case (offset_i)
      4'd0:    cand_s = window_s[9:0];
      4'd1:    cand_s = window_s[10:1];
      4'd2:    cand_s = window_s[11:2];
      4'd3:    cand_s = window_s[12:3];
      4'd4:    cand_s = window_s[13:4];
      4'd5:    cand_s = window_s[14:5];
      4'd6:    cand_s = window_s[15:6];
      4'd7:    cand_s = window_s[16:7];
      4'd8:    cand_s = window_s[17:8];
      4'd9:    cand_s = window_s[18:9];
      default: cand_s = window_s[9:0];
    endcase
  end

  // Word history and symbol registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      raw_q   <= 10'd0;
      raw_p_q <= 10'd0;
      sym_q   <= 10'd0;
    end else begin
      raw_q   <= din_i;
      raw_p_q <= raw_q;
      sym_q   <= cand_s;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
// One TMDS receive channel: bit-slip word alignment on control-token runs and
// symbol decode to pixel component / c0 / c1 / de.
// Parameters:
//   LOCK_CNT : consecutive tokens needed to declare lock (2..255)
//   TIMEOUT  : cycles without a completed run before advancing the offset
// Ports:
//   clkin      : pixel clock
//   rstin      : asynchronous active-high reset
//   din        : raw deserialized word, bit 0 earliest
//   dout       : decoded pixel component
//   c0, c1     : decoded control bits
//   de         : data enable
//   locked     : alignment achieved
//   offset     : current bit-slip offset, 0..9
//   relock_cnt : saturating count of lock losses
// Build option: TMDS_DECODER_RELOCK_CNT_EN enables relock_cnt; otherwise it
// reads 0 and the counter is not built.
// -----------------------------------------------------------------------------
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic       clkin,
  input  logic       rstin,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset,
  output logic [7:0] relock_cnt
);

  localparam int            TW         = $clog2(TIMEOUT);
  localparam logic [7:0]    RUN_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  align_state_e  state_q, state_d;
  logic [7:0]    run_q, run_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    offset_q, offset_d;
  logic [7:0]    dout_q, dout_d;
  logic          c0_q, c0_d;
  logic          c1_q, c1_d;
  logic          de_q, de_d;

  logic [9:0]    sym_s;
  logic          is_tok_s;
  logic          run_done_s;
  logic          timer_exp_s;
  logic [7:0]    dec_s;

  tmds_word_align u_align (
    .clk_i    (clkin),
    .rst_i    (rstin),
    .din_i    (din),
    .offset_i (offset_q),
    .sym_o    (sym_s)
  );

  assign is_tok_s    = is_ctrl_token(sym_s);
  assign run_done_s  = is_tok_s && (run_q == RUN_LAST);
  assign timer_exp_s = (timer_q == TIMER_LAST);
  assign dec_s       = tmds_decode(sym_s);

  // Aligner next state: a completed run takes priority over timer expiry.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    timer_d  = timer_q + 1'b1;
    offset_d = offset_q;
    if (run_done_s) begin
      state_d = LOCKED;
      run_d   = 8'd0;
      timer_d = {TW{1'b0}};
    end else if (timer_exp_s) begin
      state_d  = SEARCH;
      run_d    = 8'd0;
      timer_d  = {TW{1'b0}};
      offset_d = (offset_q == 4'd9) ? 4'd0 : (offset_q + 4'd1);
    end else if (is_tok_s) begin
      run_d = run_q + 8'd1;
    end else begin
      run_d = 8'd0;
    end
  end

  // Output next state: zeros while searching, else token or data decode.
  always_comb begin
    dout_d = 8'h00;
    c0_d   = 1'b0;
    c1_d   = 1'b0;
    de_d   = 1'b0;
    if (state_q == LOCKED) begin
      if (is_tok_s) begin
        case (sym_s)
          CTRLTOKEN1: c0_d = 1'b1;
          CTRLTOKEN2: c1_d = 1'b1;
          CTRLTOKEN3: begin
            c0_d = 1'b1;
            c1_d = 1'b1;
          end
          default: begin
            c0_d = 1'b0;
            c1_d = 1'b0;
          end
        endcase
      end else begin
        dout_d = dec_s;
        c0_d   = c0_q;
        c1_d   = c1_q;
        de_d   = 1'b1;
      end
    end else begin
      dout_d = 8'h00;
    end
  end

  // Aligner and output registers.
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      state_q  <= SEARCH;
      run_q    <= 8'd0;
      timer_q  <= {TW{1'b0}};
      offset_q <= 4'd0;
      dout_q   <= 8'h00;
      c0_q     <= 1'b0;
      c1_q     <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      timer_q  <= timer_d;
      offset_q <= offset_d;
      dout_q   <= dout_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      de_q     <= de_d;
    end
  end

`ifdef TMDS_DECODER_RELOCK_CNT_EN
  logic       lock_lost_s;
  logic [7:0] relock_q, relock_d;

  assign lock_lost_s = timer_exp_s && !run_done_s && (state_q == LOCKED);

  // Saturating lock-loss counter.
  always_comb begin
    if (lock_lost_s && (relock_q != 8'hFF)) begin
      relock_d = relock_q + 8'd1;
    end else begin
      relock_d = relock_q;
    end
  end

  // Lock-loss counter register; cleared only by reset.
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      relock_q <= 8'd0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_cnt = relock_q;
`else
  assign relock_cnt = 8'h00;
`endif

  assign dout   = dout_q;
  assign c0     = c0_q;
  assign c1     = c1_q;
  assign de     = de_q;
  assign locked = (state_q == LOCKED);
  assign offset = offset_q;

endmodule
